// File: rtl/from_hex_pkg.sv
// rtl/from_hex_pkg.sv - shared state encoding and ASCII constants for the hex parser
package from_hex_pkg;

  typedef enum logic [1:0] {
    ST_HI   = 2'd0,
    ST_LO   = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_A   = 8'h41;
  localparam logic [7:0] CH_F   = 8'h46;
  localparam logic [7:0] CH_LA  = 8'h61;
  localparam logic [7:0] CH_LF  = 8'h66;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_NL  = 8'h0A;

endpackage

// File: rtl/hex_nibble_decode.sv
// rtl/hex_nibble_decode.sv - classifies one ASCII character as hex digit / separator
// Macro FROM_HEX_LOWER_EN: accept 'a'-'f' as hex digits.
module hex_nibble_decode
  import from_hex_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_hex_o,
  output logic       is_sep_o,
  output logic [3:0] nibble_o
);

  // Digits and letters both carry their value in the low ASCII nibble (letters offset by 9).
  always_comb begin
    is_hex_o = 1'b0;
    nibble_o = 4'd0;
    if (char_i >= CH_0 && char_i <= CH_9) begin
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0];
    end else if (char_i >= CH_A && char_i <= CH_F) begin
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0] + 4'd9;
    end
`ifdef FROM_HEX_LOWER_EN
    else if (char_i >= CH_LA && char_i <= CH_LF) begin
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0] + 4'd9;
    end
`else
`endif
  end

  assign is_sep_o = (char_i == CH_SP) || (char_i == CH_TAB) ||
                    (char_i == CH_CR) || (char_i == CH_NL);

endmodule

// File: rtl/from_hex.sv
// rtl/from_hex.sv - ASCII hex character stream to byte parser (rx_rdy/rx_ack in, tx_en/tx_ack out)
// Macro FROM_HEX_LOWER_EN (via hex_nibble_decode): lowercase hex digits accepted.
module from_hex
  import from_hex_pkg::*;
#(
  parameter bit SKIP_SEP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic       rx_ack,
  input  logic       tx_ack,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       err
);

  state_t     state_q;
  logic [3:0] nib_q;
  logic [7:0] tx_data_q;
  logic       rx_ack_q;
  logic       err_q;

  logic       is_hex;
  logic       is_sep;
  logic [3:0] nibble;
  logic       accept;

  hex_nibble_decode u_dec (
    .char_i   (rx_data),
    .is_hex_o (is_hex),
    .is_sep_o (is_sep),
    .nibble_o (nibble)
  );

  // The ack cycle is never an accept cycle, so a source still holding rx_rdy is not re-sampled.
  assign accept = rx_rdy && !rx_ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HI;
      nib_q     <= 4'd0;
      tx_data_q <= 8'd0;
      rx_ack_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_ack_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_HI: begin
          if (accept) begin
            rx_ack_q <= 1'b1;
            if (is_hex) begin
              nib_q   <= nibble;
              state_q <= ST_LO;
            end else if (!(SKIP_SEP && is_sep)) begin
              err_q <= 1'b1;
            end
          end
        end
        ST_LO: begin
          if (accept) begin
            rx_ack_q <= 1'b1;
            if (is_hex) begin
              tx_data_q <= {nib_q, nibble};
              state_q   <= ST_SEND;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_HI;
            end
          end
        end
        ST_SEND: begin
          if (tx_ack) state_q <= ST_HI;
        end
        default: state_q <= ST_HI;
      endcase
    end
  end

  assign rx_ack  = rx_ack_q;
  assign err     = err_q;
  assign tx_data = tx_data_q;
  assign tx_en   = (state_q == ST_SEND);

endmodule

// File: tb/tb_from_hex.sv
// tb/tb_from_hex.sv - self-checking bench for from_hex (instance 0 SKIP_SEP=1, instance 1 SKIP_SEP=0)
module tb_from_hex;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data [2];
  logic       rx_rdy  [2];
  logic       rx_ack  [2];
  logic       tx_ack  [2];
  logic [7:0] tx_data [2];
  logic       tx_en   [2];
  logic       err     [2];

  int checks = 0;
  int errors = 0;

  from_hex #(.SKIP_SEP(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data[0]), .rx_rdy(rx_rdy[0]), .rx_ack(rx_ack[0]),
    .tx_ack(tx_ack[0]), .tx_data(tx_data[0]), .tx_en(tx_en[0]), .err(err[0])
  );

  from_hex #(.SKIP_SEP(1'b0)) dut_nosep (
    .clk(clk), .rst(rst), .rx_data(rx_data[1]), .rx_rdy(rx_rdy[1]), .rx_ack(rx_ack[1]),
    .tx_ack(tx_ack[1]), .tx_data(tx_data[1]), .tx_en(tx_en[1]), .err(err[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int s, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got 0x%0h want 0x%0h at %0t", name, s, act, exp, $time);
    end
  endtask

  // Reference: what a hex parser must do, expressed as pending-nibble / pending-byte bookkeeping.
  int         m_hi   [2];
  bit         m_pend [2];
  logic [7:0] m_data [2];
  bit         m_ack  [2];
  bit         m_err  [2];

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
`ifdef FROM_HEX_LOWER_EN
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
`endif
    return -1;
  endfunction

  function automatic bit is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0D) || (c == 8'h0A);
  endfunction

  always @(posedge clk or posedge rst) begin
    int v;
    bit na, ne;
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        m_hi[s] = -1; m_pend[s] = 0; m_data[s] = 8'h00; m_ack[s] = 0; m_err[s] = 0;
      end else begin
        na = 0; ne = 0;
        if (m_pend[s]) begin
          if (tx_ack[s]) m_pend[s] = 0;
        end else if (rx_rdy[s] && !m_ack[s]) begin
          na = 1;
          v = hexval(rx_data[s]);
          if (m_hi[s] < 0) begin
            if (v >= 0) m_hi[s] = v;
            else if (!(s == 0 && is_ws(rx_data[s]))) ne = 1;
          end else begin
            if (v >= 0) begin
              m_data[s] = 8'(m_hi[s] * 16 + v);
              m_pend[s] = 1;
            end else ne = 1;
            m_hi[s] = -1;
          end
        end
        m_ack[s] = na;
        m_err[s] = ne;
      end
    end
  end

  bit         prev_en  [2];
  int         got_cnt  [2];
  logic [15:0] got_hist [2];
  int         errc     [2];
  int         ackc     [2];
  bit         auto_sink[2];

  // Per-cycle compare against the reference plus event logging for the directed checks.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      chk("rx_ack", s, int'(rx_ack[s]), int'(m_ack[s]));
      chk("err", s, int'(err[s]), int'(m_err[s]));
      chk("tx_en", s, int'(tx_en[s]), int'(m_pend[s]));
      chk("tx_data", s, int'(tx_data[s]), int'(m_data[s]));
      if (rst) prev_en[s] = 0;
      else begin
        if (tx_en[s] === 1'b1 && !prev_en[s]) begin
          got_cnt[s]++;
          got_hist[s] = {got_hist[s][7:0], tx_data[s]};
        end
        prev_en[s] = (tx_en[s] === 1'b1);
        if (err[s] === 1'b1) errc[s]++;
        if (rx_ack[s] === 1'b1) ackc[s]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++)
      if (auto_sink[s]) tx_ack[s] = (tx_en[s] === 1'b1) && !tx_ack[s];
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_log(input int s);
    got_cnt[s] = 0; got_hist[s] = 16'h0; errc[s] = 0; ackc[s] = 0;
  endtask

  // Source keeps rx_rdy and the old character through the ack-high edge before moving on.
  task automatic send_char(input int s, input logic [7:0] c);
    int n;
    rx_data[s] = c;
    rx_rdy[s]  = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (rx_ack[s] !== 1'b1 && n < 100);
    if (rx_ack[s] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout[%0d] got no rx_ack want rx_ack for char 0x%0h", s, c);
    end
    step();
  endtask

  task automatic send_str(input int s, input string str);
    for (int i = 0; i < str.len(); i++) send_char(s, str[i]);
    rx_rdy[s] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rx_data[s] = 8'h00; rx_rdy[s] = 1'b0; tx_ack[s] = 1'b0;
      auto_sink[s] = 1'b1; prev_en[s] = 0; clear_log(s);
    end
    idle(2);
    chk("rst_tx_en", 0, int'(tx_en[0]), 0);
    chk("rst_tx_data", 0, int'(tx_data[0]), 0);
    chk("rst_rx_ack", 0, int'(rx_ack[0]), 0);
    chk("rst_err", 0, int'(err[0]), 0);
    rst = 1'b0;
    idle(2);

    // "4F" with the sink stalling
    clear_log(0);
    auto_sink[0] = 1'b0;
    send_str(0, "4F");
    step();
    chk("t1_tx_en", 0, int'(tx_en[0]), 1);
    chk("t1_tx_data", 0, int'(tx_data[0]), 'h4F);
    chk("t1_acks", 0, ackc[0], 2);
    rx_data[0] = 8'h31;
    rx_rdy[0]  = 1'b1;
    idle(5);
    chk("t1_hold_tx_en", 0, int'(tx_en[0]), 1);
    chk("t1_backpressure_acks", 0, ackc[0], 2);
    rx_rdy[0] = 1'b0;
    tx_ack[0] = 1'b1;
    step();
    tx_ack[0] = 1'b0;
    chk("t1_release_tx_en", 0, int'(tx_en[0]), 0);
    chk("t1_model_byte", 0, int'(m_data[0]), 'h4F);
    chk("t1_held_tx_data", 0, int'(tx_data[0]), 'h4F);
    auto_sink[0] = 1'b1;
    idle(2);

    // separators and case handling
    clear_log(0);
    send_str(0, "0A 7e\r\n");
    idle(3);
    chk("t2_acks", 0, ackc[0], 7);
`ifdef FROM_HEX_LOWER_EN
    chk("t2_bytes", 0, got_cnt[0], 2);
    chk("t2_hist", 0, int'(got_hist[0]), 'h0A7E);
    chk("t2_errs", 0, errc[0], 0);
`else
    chk("t2_bytes", 0, got_cnt[0], 1);
    chk("t2_hist", 0, int'(got_hist[0][7:0]), 'h0A);
    chk("t2_errs", 0, errc[0], 1);
`endif

    // broken pair drops the pending nibble
    clear_log(0);
    send_str(0, "3G12");
    idle(3);
    chk("t3_errs", 0, errc[0], 1);
    chk("t3_bytes", 0, got_cnt[0], 1);
    chk("t3_byte", 0, int'(got_hist[0][7:0]), 'h12);

    // SKIP_SEP=0 instance
    clear_log(1);
    send_str(1, " ");
    idle(2);
    chk("t4_sp_err", 1, errc[1], 1);
    chk("t4_sp_ack", 1, ackc[1], 1);
    send_str(1, "5 5");
    idle(2);
    chk("t4_lo_err", 1, errc[1], 2);
    chk("t4_no_byte", 1, got_cnt[1], 0);
    send_str(1, "5");
    idle(3);
    chk("t4_bytes", 1, got_cnt[1], 1);
    chk("t4_byte", 1, int'(got_hist[1][7:0]), 'h55);

    // back-to-back with rx_rdy held
    clear_log(0);
    send_str(0, "AB");
    idle(3);
    chk("t5_acks", 0, ackc[0], 2);
    chk("t5_bytes", 0, got_cnt[0], 1);
    chk("t5_byte", 0, int'(got_hist[0][7:0]), 'hAB);
    chk("t5_errs", 0, errc[0], 0);

    // asynchronous reset while a byte is pending
    auto_sink[0] = 1'b0;
    send_str(0, "12");
    step();
    chk("t6_pre_tx_en", 0, int'(tx_en[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_tx_en", 0, int'(tx_en[0]), 0);
    chk("t6_rst_tx_data", 0, int'(tx_data[0]), 0);
    chk("t6_rst_rx_ack", 0, int'(rx_ack[0]), 0);
    chk("t6_rst_err", 0, int'(err[0]), 0);
    step();
    rst = 1'b0;
    auto_sink[0] = 1'b1;
    idle(1);
    clear_log(0);
    send_str(0, "FF");
    idle(3);
    chk("t6_bytes", 0, got_cnt[0], 1);
    chk("t6_byte", 0, int'(got_hist[0][7:0]), 'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
